// File: rtl/cpu_sequencer_if.sv
// Bus between the ROM/control side and the instruction-fetch sequencer.
// The sequencer connects through the slave modport. The ROM, the control
// decoder and the halt logic connect through the master modport.
interface cpu_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int CYC_W  = 3
);
    logic [DATA_W-1:0]   data;
    logic                ready;
    logic                halt_req;
    logic                sync;
    logic [CYC_W-1:0]    cycle;
    logic [2*DATA_W-1:0] inst;
    logic [2*DATA_W-1:0] operand;
    logic                word_index;
    logic                inst_done;
    logic                halted;

    modport slave (
        input  data,
        input  ready,
        input  halt_req,
        output sync,
        output cycle,
        output inst,
        output operand,
        output word_index,
        output inst_done,
        output halted
    );

    modport master (
        output data,
        output ready,
        output halt_req,
        input  sync,
        input  cycle,
        input  inst,
        input  operand,
        input  word_index,
        input  inst_done,
        input  halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction-fetch and subcycle sequencer for the 4-bit CPU core.
// It steps a subcycle counter and latches both halves of each ROM word.
// A slow ROM can stall the two fetch subcycles. One- and two-word
// instructions are detected from opcode masks. The unit can also park in a
// halted state at an instruction boundary.
module cpu_sequencer #(
    parameter int          DATA_W         = 4,
    parameter int          NUM_SUBCYCLES  = 8,
    parameter int          FETCH_HI       = 3,
    parameter int          FETCH_LO       = 4,
    parameter int          DECIDE_CYC     = 5,
    parameter logic [15:0] MULTI_OP_MASK  = 16'h003C,
    parameter logic [15:0] EVEN_ONLY_MASK = 16'h000C
) (
    input logic            clock,
    input logic            reset,
    cpu_sequencer_if.slave bus
);
    localparam int CYC_W = $clog2(NUM_SUBCYCLES);
    localparam logic [CYC_W-1:0] CYC_HI     = CYC_W'(FETCH_HI);
    localparam logic [CYC_W-1:0] CYC_LO     = CYC_W'(FETCH_LO);
    localparam logic [CYC_W-1:0] CYC_DECIDE = CYC_W'(DECIDE_CYC);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(NUM_SUBCYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [CYC_W-1:0]    r_cycle;
    logic [CYC_W-1:0]    w_cycleNext;
    logic [2*DATA_W-1:0] r_inst;
    logic [2*DATA_W-1:0] w_instNext;
    logic [2*DATA_W-1:0] r_operand;
    logic [2*DATA_W-1:0] w_operandNext;
    logic                r_wordIndex;
    logic                w_wordIndexNext;
    logic                w_fetchSlot;
    logic                w_stall;
    logic [3:0]          w_opcode;
    logic                w_isMulti;
    logic                w_instDone;

    assign w_opcode    = r_inst[2*DATA_W-1 -: 4];
    assign w_isMulti   = MULTI_OP_MASK[w_opcode] && !(EVEN_ONLY_MASK[w_opcode] && r_inst[0]);
    assign w_fetchSlot = (r_cycle == CYC_HI) || (r_cycle == CYC_LO);
    assign w_stall     = w_fetchSlot && !bus.ready;

    assign bus.sync       = ~(r_cycle == CYC_LAST);
    assign bus.cycle      = r_cycle;
    assign bus.inst       = r_inst;
    assign bus.operand    = r_operand;
    assign bus.word_index = r_wordIndex;
    assign bus.inst_done  = w_instDone;
    assign bus.halted     = (r_state == ST_HALTED);

    // State and datapath registers. Reset aborts any word or stall in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cycle     <= '0;
            r_inst      <= '0;
            r_operand   <= '0;
            r_wordIndex <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cycle     <= w_cycleNext;
            r_inst      <= w_instNext;
            r_operand   <= w_operandNext;
            r_wordIndex <= w_wordIndexNext;
        end
    end

    // Next-state logic. A stalled fetch freezes everything. Otherwise this
    // advances the subcycle, latches fetch data, makes the two-word decision
    // and handles halt entry/exit at instruction boundaries.
    always_comb begin
        w_stateNext     = r_state;
        w_cycleNext     = r_cycle;
        w_instNext      = r_inst;
        w_operandNext   = r_operand;
        w_wordIndexNext = r_wordIndex;
        w_instDone      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!w_stall) begin
                    w_instDone = (r_cycle == CYC_LAST) && !r_wordIndex;
                    if (r_cycle == CYC_LAST) begin
                        w_cycleNext = '0;
                    end else begin
                        w_cycleNext = r_cycle + CYC_W'(1);
                    end
                    if (r_cycle == CYC_HI) begin
                        if (r_wordIndex) begin
                            w_operandNext[2*DATA_W-1:DATA_W] = bus.data;
                        end else begin
                            w_instNext[2*DATA_W-1:DATA_W] = bus.data;
                        end
                    end
                    if (r_cycle == CYC_LO) begin
                        if (r_wordIndex) begin
                            w_operandNext[DATA_W-1:0] = bus.data;
                        end else begin
                            w_instNext[DATA_W-1:0] = bus.data;
                        end
                    end
                    if (r_cycle == CYC_DECIDE) begin
                        if (r_wordIndex) begin
                            w_wordIndexNext = 1'b0;
                        end else if (w_isMulti) begin
                            w_wordIndexNext = 1'b1;
                        end
                    end
                    if (w_instDone && bus.halt_req) begin
                        w_stateNext = ST_HALTED;
                        w_cycleNext = '0;
                    end
                end
            end
            ST_HALTED: begin
                if (!bus.halt_req) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer. The stimulus side walks through
// instructions one subcycle at a time. For every clock period it queues
// the outputs the sequencer should show. For every instruction it queues
// the inst/operand pair expected when inst_done pulses. A monitor pops
// and compares both queues.
module tb_cpu_sequencer;
    localparam int          DATA_W         = 4;
    localparam int          NSUB           = 8;
    localparam int          FETCH_HI       = 3;
    localparam int          FETCH_LO       = 4;
    localparam int          DECIDE_CYC     = 5;
    localparam logic [15:0] MULTI_OP_MASK  = 16'h003C;
    localparam logic [15:0] EVEN_ONLY_MASK = 16'h000C;
    localparam int          CYC_W          = $clog2(NSUB);

    typedef struct packed {
        logic [CYC_W-1:0]    cycle;
        logic                sync;
        logic                wordIndex;
        logic                instDone;
        logic                halted;
        logic                chkData;
        logic [2*DATA_W-1:0] inst;
        logic [2*DATA_W-1:0] operand;
    } obs_t;

    typedef struct packed {
        logic [2*DATA_W-1:0] inst;
        logic [2*DATA_W-1:0] operand;
    } txn_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    obs_t expQ[$];
    txn_t txnQ[$];
    int   errors = 0;
    int   checks = 0;

    logic [2*DATA_W-1:0] modelInst    = '0;
    logic [2*DATA_W-1:0] modelOperand = '0;

    cpu_sequencer_if #(.DATA_W(DATA_W), .CYC_W(CYC_W)) bus ();

    cpu_sequencer #(
        .DATA_W        (DATA_W),
        .NUM_SUBCYCLES (NSUB),
        .FETCH_HI      (FETCH_HI),
        .FETCH_LO      (FETCH_LO),
        .DECIDE_CYC    (DECIDE_CYC),
        .MULTI_OP_MASK (MULTI_OP_MASK),
        .EVEN_ONLY_MASK(EVEN_ONLY_MASK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference rule for instruction length. An opcode listed in the
    // multi-word table takes two words, unless it is an even-only opcode
    // whose low bit is set.
    function automatic bit isTwoWord(input logic [7:0] w);
        logic [3:0] op;
        op = w[7:4];
        if (!MULTI_OP_MASK[op]) return 1'b0;
        if (EVEN_ONLY_MASK[op] && w[0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one clock period of inputs and queue the outputs expected in that period.
    task automatic applyStimulus(input logic [3:0] d, input logic rdy, input logic halt,
                                 input logic rst, input obs_t e);
        @(negedge clock);
        reset        = rst;
        bus.data     = d;
        bus.ready    = rdy;
        bus.halt_req = halt;
        expQ.push_back(e);
    endtask

    // One ROM word, spread across all subcycles. Each fetch slot can be
    // stretched by stalls, and junk data is driven while a slot is stalled.
    task automatic runWord(input logic [3:0] hi, input logic [3:0] lo, input int stallHi,
                           input int stallLo, input bit second, input bit two,
                           input int haltFrom, input int abortAt);
        obs_t e;
        for (int s = 0; s < NSUB; s++) begin
            int reps;
            reps = (s == FETCH_HI) ? stallHi + 1 : (s == FETCH_LO) ? stallLo + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                logic [3:0] d;
                logic       rdy;
                bit         last;
                last = (r == reps - 1);
                d    = 4'($urandom);
                rdy  = 1'($urandom);
                if (s == FETCH_HI || s == FETCH_LO) rdy = last;
                if (last && s == FETCH_HI) d = hi;
                if (last && s == FETCH_LO) d = lo;
                e.cycle     = CYC_W'(s);
                e.sync      = (s != NSUB - 1);
                e.wordIndex = two && (second ? (s <= DECIDE_CYC) : (s > DECIDE_CYC));
                e.instDone  = (s == NSUB - 1) && (!two || second);
                e.halted    = 1'b0;
                e.chkData   = (s == 0) && (r == 0);
                e.inst      = modelInst;
                e.operand   = modelOperand;
                applyStimulus(d, rdy, (s >= haltFrom), (s == abortAt), e);
            end
            if (s == abortAt) return;
        end
        if (second) modelOperand = {hi, lo};
        else        modelInst    = {hi, lo};
    endtask

    // Halted periods. halt_req is held high and then dropped in the last
    // halted period, so the following period is subcycle 0 of the next word.
    task automatic runHalt(input int len);
        obs_t e;
        for (int h = 0; h < len; h++) begin
            e.cycle     = '0;
            e.sync      = 1'b1;
            e.wordIndex = 1'b0;
            e.instDone  = 1'b0;
            e.halted    = 1'b1;
            e.chkData   = 1'b1;
            e.inst      = modelInst;
            e.operand   = modelOperand;
            applyStimulus(4'($urandom), 1'($urandom), (h < len - 1), 1'b0, e);
        end
    endtask

    // One complete instruction: one or two words plus an optional halt afterwards.
    task automatic runInstr(input logic [7:0] w0, input logic [7:0] w1, input int stallHi,
                            input int stallLo, input int haltFrom, input int haltLen);
        bit   two;
        txn_t t;
        two       = isTwoWord(w0);
        t.inst    = w0;
        t.operand = two ? w1 : modelOperand;
        if (!two) txnQ.push_back(t);
        runWord(w0[7:4], w0[3:0], stallHi, stallLo, 1'b0, two, haltFrom, -1);
        if (two) begin
            txnQ.push_back(t);
            runWord(w1[7:4], w1[3:0], stallLo, stallHi, 1'b1, 1'b1,
                    (haltFrom < NSUB) ? 0 : NSUB, -1);
        end
        if (haltFrom < NSUB) runHalt(haltLen);
    endtask

    // Monitor: compares every queued period and every inst_done pulse.
    initial begin
        obs_t e;
        txn_t t;
        forever begin
            @(negedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cycleState",
                            32'({bus.cycle, bus.sync, bus.word_index, bus.inst_done, bus.halted}),
                            32'({e.cycle, e.sync, e.wordIndex, e.instDone, e.halted}));
                if (e.chkData)
                    checkOutput("instOperand", 32'({bus.inst, bus.operand}), 32'({e.inst, e.operand}));
            end
            if (bus.inst_done === 1'b1) begin
                if (txnQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL txnUnexpected: got inst_done=1, expected no completion at %0t", $time);
                end else begin
                    t = txnQ.pop_front();
                    checkOutput("doneInst", 32'(bus.inst), 32'(t.inst));
                    checkOutput("doneOperand", 32'(bus.operand), 32'(t.operand));
                end
            end
        end
    end

    // Stimulus: directed cases first, then randomized instructions.
    initial begin
        bus.data     = '0;
        bus.ready    = 1'b0;
        bus.halt_req = 1'b0;
        repeat (3) @(posedge clock);

        runInstr(8'hD7, 8'h00, 0, 0, NSUB, 0);
        runInstr(8'h42, 8'hA5, 0, 0, NSUB, 0);
        runInstr(8'h23, 8'h00, 0, 0, NSUB, 0);
        runInstr(8'h22, 8'h6B, 0, 0, NSUB, 0);
        runInstr(8'h31, 8'h00, 0, 0, NSUB, 0);
        runInstr(8'h30, 8'h9E, 0, 0, NSUB, 0);
        runInstr(8'hB4, 8'h00, 3, 0, NSUB, 0);
        runInstr(8'h51, 8'h20, 1, 2, 1, 3);

        runWord(4'h5, 4'h0, 0, 0, 1'b0, 1'b1, NSUB, 6);
        modelInst    = '0;
        modelOperand = '0;
        runInstr(8'h6C, 8'h00, 0, 1, 0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] w0;
            logic [7:0] w1;
            int         sh;
            int         sl;
            int         hf;
            int         hl;
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            sh = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            sl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            hf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NSUB - 1)) : NSUB;
            hl = int'($urandom_range(1, 4));
            runInstr(w0, w1, sh, sl, hf, hl);
        end

        repeat (2) @(negedge clock);
        #2;
        checkOutput("expDrain", 32'(expQ.size()), 32'd0);
        checkOutput("txnDrain", 32'(txnQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
